// File: rtl/dm_sized.sv
// Byte-addressed data memory with byte/half/word big-endian lanes.
// Requests use a req/ready handshake with LATENCY wait states and report misaligned accesses.
module dm_sized #(
    parameter int ADDR_W  = 7,
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uext,
    input  logic [ADDR_W+1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT =
        (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uext_q, uext_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mis_q, mis_d;

    logic [31:0] mem [2**ADDR_W];

    logic              accept;
    logic              commit;
    logic              c_we;
    logic [1:0]        c_size;
    logic              c_uext;
    logic [ADDR_W+1:0] c_addr;
    logic [31:0]       c_wdata;
    logic              c_mis;
    logic [31:0]       cur_word;
    logic [31:0]       lane_mask;
    logic [4:0]        sh_amt;
    logic [31:0]       lane_val;
    logic [31:0]       load_val;
    logic [31:0]       wr_word;

    // Select the request being committed (fresh on a zero-latency accept) and build lanes.
    always_comb begin
        accept  = req && (state_q == IDLE || state_q == RESP);
        c_we    = accept ? we    : we_q;
        c_size  = accept ? size  : size_q;
        c_uext  = accept ? uext  : uext_q;
        c_addr  = accept ? addr  : addr_q;
        c_wdata = accept ? wdata : wdata_q;

        commit  = (accept && LATENCY == 0) ||
                  (state_q == WAIT && cnt_q == 4'd0);

        unique case (c_size)
            2'b00:   c_mis = 1'b0;
            2'b01:   c_mis = c_addr[0];
            2'b10:   c_mis = (c_addr[1:0] != 2'b00);
            default: c_mis = 1'b1;
        endcase

        unique case (c_size)
            2'b00: begin
                lane_mask = 32'h0000_00ff;
                sh_amt    = {~c_addr[1:0], 3'b000};
            end
            2'b01: begin
                lane_mask = 32'h0000_ffff;
                sh_amt    = {~c_addr[1], 4'b0000};
            end
            default: begin
                lane_mask = 32'hffff_ffff;
                sh_amt    = 5'd0;
            end
        endcase

        cur_word = mem[c_addr[ADDR_W+1:2]];
        lane_val = (cur_word >> sh_amt) & lane_mask;

        unique case (c_size)
            2'b00:   load_val = c_uext ? lane_val
                              : {{24{lane_val[7]}}, lane_val[7:0]};
            2'b01:   load_val = c_uext ? lane_val
                              : {{16{lane_val[15]}}, lane_val[15:0]};
            default: load_val = lane_val;
        endcase

        wr_word = (cur_word & ~(lane_mask << sh_amt)) |
                  ((c_wdata & lane_mask) << sh_amt);
    end

    // Next-state, wait counter, request latch and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uext_d  = uext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;

        if (accept) begin
            we_d    = we;
            size_d  = size;
            uext_d  = uext;
            addr_d  = addr;
            wdata_d = wdata;
        end

        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            mis_d = c_mis;
            if (c_mis) begin
                rdata_d = 32'd0;
            end else if (!c_we) begin
                rdata_d = load_val;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uext_q  <= uext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Memory array is never cleared; a store lands on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (!reset && commit && c_we && !c_mis) begin
            mem[c_addr[ADDR_W+1:2]] <= wr_word;
        end
    end

    assign ready    = (state_q == RESP);
    assign misalign = (state_q == RESP) && mis_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_dm_sized.sv
// Testbench for dm_sized: directed vector table at LATENCY=0,
// plus throughput and reset-abort sequences at LATENCY=3.
module tb_dm_sized;

    logic        clk = 1'b0;
    logic        reset;

    logic        req0, we0, uext0;
    logic [1:0]  size0;
    logic [8:0]  addr0;
    logic [31:0] wdata0, rdata0;
    logic        ready0, mis0;

    logic        req3, we3, uext3;
    logic [1:0]  size3;
    logic [8:0]  addr3;
    logic [31:0] wdata3, rdata3;
    logic        ready3, mis3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_sized #(.ADDR_W(7), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0),
        .size(size0), .uext(uext0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .misalign(mis0)
    );

    dm_sized #(.ADDR_W(7), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .we(we3),
        .size(size3), .uext(uext3), .addr(addr3), .wdata(wdata3),
        .rdata(rdata3), .ready(ready3), .misalign(mis3)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uext;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t tv [21];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for ready on dut3, returns cycles after accept or -1 on timeout.
    task automatic wait3(output int n);
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            req3 = 1'b0;
            if (ready3) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic issue3(input logic w, input logic [8:0] a,
                          input logic [31:0] d);
        @(negedge clk);
        req3  = 1'b1;
        we3   = w;
        size3 = 2'b10;
        uext3 = 1'b0;
        addr3 = a;
        wdata3 = d;
    endtask

    initial begin
        int n;

        // we size uext addr wdata chk_rd exp_rd exp_mis
        tv[0]  = '{1'b1, 2'b10, 1'b0, 9'h010, 32'h11223344, 1'b0, 32'h0, 1'b0};
        tv[1]  = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 1'b1, 32'h11223344, 1'b0};
        tv[2]  = '{1'b1, 2'b00, 1'b0, 9'h012, 32'h000000AB, 1'b0, 32'h0, 1'b0};
        tv[3]  = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 1'b1, 32'h1122AB44, 1'b0};
        tv[4]  = '{1'b1, 2'b01, 1'b0, 9'h010, 32'h0000BEEF, 1'b0, 32'h0, 1'b0};
        tv[5]  = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 1'b1, 32'hBEEFAB44, 1'b0};
        tv[6]  = '{1'b1, 2'b10, 1'b0, 9'h020, 32'h80FF7F00, 1'b0, 32'h0, 1'b0};
        tv[7]  = '{1'b0, 2'b00, 1'b0, 9'h020, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0};
        tv[8]  = '{1'b0, 2'b00, 1'b1, 9'h020, 32'h0, 1'b1, 32'h00000080, 1'b0};
        tv[9]  = '{1'b0, 2'b01, 1'b0, 9'h022, 32'h0, 1'b1, 32'h00007F00, 1'b0};
        tv[10] = '{1'b0, 2'b01, 1'b0, 9'h020, 32'h0, 1'b1, 32'hFFFF80FF, 1'b0};
        tv[11] = '{1'b0, 2'b01, 1'b1, 9'h020, 32'h0, 1'b1, 32'h000080FF, 1'b0};
        tv[12] = '{1'b0, 2'b00, 1'b1, 9'h021, 32'h0, 1'b1, 32'h000000FF, 1'b0};
        tv[13] = '{1'b0, 2'b00, 1'b0, 9'h022, 32'h0, 1'b1, 32'h0000007F, 1'b0};
        tv[14] = '{1'b0, 2'b10, 1'b0, 9'h022, 32'h0, 1'b1, 32'h00000000, 1'b1};
        tv[15] = '{1'b1, 2'b01, 1'b0, 9'h021, 32'h00001234, 1'b1, 32'h0, 1'b1};
        tv[16] = '{1'b1, 2'b11, 1'b0, 9'h020, 32'h0, 1'b1, 32'h0, 1'b1};
        tv[17] = '{1'b0, 2'b10, 1'b0, 9'h020, 32'h0, 1'b1, 32'h80FF7F00, 1'b0};
        tv[18] = '{1'b1, 2'b00, 1'b0, 9'h021, 32'hFFFFFF55, 1'b0, 32'h0, 1'b0};
        tv[19] = '{1'b0, 2'b10, 1'b0, 9'h020, 32'h0, 1'b1, 32'h80557F00, 1'b0};
        tv[20] = '{1'b0, 2'b01, 1'b1, 9'h022, 32'h0, 1'b1, 32'h00007F00, 1'b0};

        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; size0 = 2'b00; uext0 = 1'b0;
        addr0 = '0; wdata0 = '0;
        req3 = 1'b0; we3 = 1'b0; size3 = 2'b00; uext3 = 1'b0;
        addr3 = '0; wdata3 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready0", {31'd0, ready0}, 32'd0);
        chk("rst_mis0", {31'd0, mis0}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_ready3", {31'd0, ready3}, 32'd0);
        chk("rst_rdata3", rdata3, 32'd0);

        // LATENCY=0 vector table: ready exactly one cycle after accept.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            chk($sformatf("idle_ready[%0d]", i), {31'd0, ready0}, 32'd0);
            req0 = 1'b1;
            we0 = tv[i].we; size0 = tv[i].size; uext0 = tv[i].uext;
            addr0 = tv[i].addr; wdata0 = tv[i].wdata;
            @(negedge clk);
            req0 = 1'b0;
            chk($sformatf("ready[%0d]", i), {31'd0, ready0}, 32'd1);
            chk($sformatf("mis[%0d]", i), {31'd0, mis0}, {31'd0, tv[i].exp_mis});
            if (tv[i].chk_rd)
                chk($sformatf("rdata[%0d]", i), rdata0, tv[i].exp_rd);
        end

        // LATENCY=0 back-to-back: store then load accepted in RESP.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; size0 = 2'b10; addr0 = 9'h030;
        wdata0 = 32'hA5A55A5A;
        @(negedge clk);
        chk("b2b_ready_st", {31'd0, ready0}, 32'd1);
        we0 = 1'b0;
        @(negedge clk);
        req0 = 1'b0;
        chk("b2b_ready_ld", {31'd0, ready0}, 32'd1);
        chk("b2b_rdata", rdata0, 32'hA5A55A5A);

        // LATENCY=3: store, then single load, both with 4-cycle latency.
        issue3(1'b1, 9'h040, 32'hCAFEF00D);
        wait3(n);
        chk("l3_st_lat", n, 4);
        issue3(1'b0, 9'h040, 32'h0);
        wait3(n);
        chk("l3_ld_lat", n, 4);
        chk("l3_ld_rdata", rdata3, 32'hCAFEF00D);

        // LATENCY=3 throughput: req held high, one pulse every 4 cycles.
        issue3(1'b0, 9'h040, 32'h0);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 16) req3 = 1'b0;
            chk($sformatf("l3_tp_ready[%0d]", c), {31'd0, ready3},
                {31'd0, (c % 4 == 0)});
            if (c % 4 == 0)
                chk($sformatf("l3_tp_rdata[%0d]", c), rdata3, 32'hCAFEF00D);
        end

        // LATENCY=3: reset during WAIT drops the store, no ready follows.
        issue3(1'b1, 9'h040, 32'h12345678);
        @(negedge clk);
        req3 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("l3_abort_ready[%0d]", c), {31'd0, ready3}, 32'd0);
        end
        chk("l3_abort_rdata", rdata3, 32'd0);
        issue3(1'b0, 9'h040, 32'h0);
        wait3(n);
        chk("l3_abort_lat", n, 4);
        chk("l3_abort_word", rdata3, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
